// File: rtl/board_uart_loader_pkg.sv
// ============================================================================
// Module : board_uart_loader_pkg
// Brief  : Shared constants for the serial Game of Life board loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package board_uart_loader_pkg;

    localparam int          MAX_X_DEF        = 32;
    localparam int          MAX_Y_DEF        = 24;
    localparam int          CLKS_PER_BIT_DEF = 434;
    localparam int          TIMEOUT_CLKS_DEF = 50000;
    localparam logic [7:0]  SYNC_BYTE        = 8'hA5;

    // One payload byte carries eight consecutive cells, LSB = lowest index.
    function automatic int nbytes(input int mx, input int my);
        return (mx * my) / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/board_uart_loader_uart_rx_byte.sv
// ============================================================================
// Module : uart_rx_byte
// Brief  : 2-FF synchronizer plus 8N1 byte receiver with stop-bit check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import board_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_done_o,
    output logic [7:0] data_o,
    output logic       stop_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;

    // Synchronizer and edge history idle high so a low line after reset is no edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        byte_done_o = 1'b0;
        stop_err_o  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (prev_q && !sync2_q) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = R_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    byte_done_o = sync2_q;
                    stop_err_o  = !sync2_q;
                    state_d     = R_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign data_o = shift_q;

endmodule

`default_nettype wire

// File: rtl/board_uart_loader.sv
// ============================================================================
// Module : board_uart_loader
// Brief  : Receives a sync-framed, XOR-checked board image over UART and
//          commits it to board_out only when the checksum matches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module board_uart_loader
    import board_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int MAX_X        = MAX_X_DEF,
    parameter int MAX_Y        = MAX_Y_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    output logic [MAX_X*MAX_Y-1:0] board_out,
    output logic                   board_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int NBITS  = MAX_X * MAX_Y;
    localparam int NBYTES = nbytes(MAX_X, MAX_Y);
    localparam int BCW    = $clog2(NBYTES);
    localparam int TOW    = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] F_SYNC    = 2'd0;
    localparam logic [1:0] F_PAYLOAD = 2'd1;
    localparam logic [1:0] F_CHECK   = 2'd2;

    logic             rx_done;
    logic             rx_stop_err;
    logic [7:0]       rx_data;

    logic [1:0]       state_q, state_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [7:0]       xsum_q, xsum_d;
    logic [TOW-1:0]   to_q, to_d;
    logic [NBITS-1:0] stage_q, stage_d;
    logic [NBITS-1:0] board_q, board_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_in),
        .byte_done_o (rx_done),
        .data_o      (rx_data),
        .stop_err_o  (rx_stop_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= F_SYNC;
            bcnt_q  <= '0;
            xsum_q  <= '0;
            to_q    <= '0;
            stage_q <= '0;
            board_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            xsum_q  <= xsum_d;
            to_q    <= to_d;
            stage_q <= stage_d;
            board_q <= board_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        xsum_d  = xsum_q;
        to_d    = '0;
        stage_d = stage_q;
        board_d = board_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            F_SYNC: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    state_d = F_PAYLOAD;
                    bcnt_d  = '0;
                    xsum_d  = '0;
                end
            end
            F_PAYLOAD, F_CHECK: begin
                // A received byte restarts the idle timer; the stop error and
                // the timeout both abandon the frame with a single error pulse.
                if (rx_done) begin
                    if (state_q == F_PAYLOAD) begin
                        stage_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                        xsum_d = xsum_q ^ rx_data;
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == LAST_BYTE) state_d = F_CHECK;
                    end else begin
                        if (rx_data == xsum_q) begin
                            board_d = stage_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = F_SYNC;
                    end
                end else if (rx_stop_err || to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = F_SYNC;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = F_SYNC;
        endcase
    end

    assign board_out   = board_q;
    assign board_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != F_SYNC);

endmodule

`default_nettype wire

// File: tb/tb_board_uart_loader.sv
// ============================================================================
// Module : tb_board_uart_loader
// Brief  : Scoreboard bench for board_uart_loader with a short bit time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_uart_loader;

    localparam int CPB    = 8;
    localparam int TO     = 400;
    localparam int NBITS  = 32 * 24;
    localparam int NBYTES = NBITS / 8;

    typedef struct {
        bit               is_err;
        logic [NBITS-1:0] board;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rx_in = 1'b1;
    logic [NBITS-1:0] board_out;
    logic             board_valid;
    logic             frame_err;
    logic             busy;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               err_cyc = 0;
    int               n_valid = 0;
    int               n_err = 0;
    exp_t             sbq[$];
    logic [7:0]       pay [NBYTES];
    logic [NBITS-1:0] model_board = '0;

    board_uart_loader #(
        .CLKS_PER_BIT (CPB),
        .MAX_X        (32),
        .MAX_Y        (24),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .board_out   (board_out),
        .board_valid (board_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (board_valid || frame_err)) begin
            if (board_valid) n_valid++;
            if (frame_err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (sbq.size() == 0) begin
                chk("unexpected_evt", {board_valid, frame_err}, 2'b00);
            end else begin
                e = sbq.pop_front();
                chk("evt_kind", {board_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
                chk("evt_board", board_out, e.board);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
    endtask

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NBYTES; k++) x ^= pay[k];
        return x;
    endfunction

    function automatic logic [NBITS-1:0] pay_board();
        logic [NBITS-1:0] b = '0;
        for (int k = 0; k < NBYTES; k++) b[8*k +: 8] = pay[k];
        return b;
    endfunction

    task automatic send_frame(input logic [7:0] ck, input bit good);
        exp_t e;
        send_byte(8'hA5, 1'b1);
        for (int k = 0; k < NBYTES; k++) send_byte(pay[k], 1'b1);
        if (good) model_board = pay_board();
        e.is_err = !good;
        e.board  = model_board;
        sbq.push_back(e);
        send_byte(ck, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   t0;
        logic [NBITS-1:0] b1;

        repeat (5) @(negedge clk);
        chk("rst_board", board_out, '0);
        chk("rst_flags", {board_valid, frame_err, busy}, 3'b000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: all 0x01 payload, good checksum
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'h01;
        chk("t1_xor", pay_xor(), 8'h00);
        send_frame(8'h00, 1'b1);
        b1 = '0;
        for (int k = 0; k < NBYTES; k++) b1[8*k] = 1'b1;
        chk("t1_board", board_out, b1);

        // 2: same frame, bad checksum
        send_frame(8'h01, 1'b0);
        chk("t2_board_kept", board_out, b1);

        // 3: junk bytes then glider
        send_byte(8'h00, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        chk("t3_sync_idle", busy, 1'b0);
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'h00;
        pay[0] = 8'h02; pay[4] = 8'h04; pay[8] = 8'h07;
        send_frame(pay_xor(), 1'b1);
        chk("t3_glider", {board_out[1], board_out[34], board_out[64], board_out[65], board_out[66]}, 5'b11111);
        chk("t3_popcount", $countones(board_out), 5);

        // 4: timeout after 40 payload bytes
        send_byte(8'hA5, 1'b1);
        chk("t4_busy", busy, 1'b1);
        for (int k = 0; k < 40; k++) send_byte(8'h5A, 1'b1);
        e.is_err = 1'b1;
        e.board  = model_board;
        sbq.push_back(e);
        t0 = cyc;
        repeat (500) @(negedge clk);
        chk("t4_busy_drop", busy, 1'b0);
        chk("t4_to_window", ((err_cyc - t0) >= 390 && (err_cyc - t0) <= 410), 1'b1);
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'(k * 7 + 3);
        pay[10] = 8'hA5;
        send_frame(pay_xor(), 1'b1);

        // 5: stop-bit error in payload, then short glitch on idle line
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        e.is_err = 1'b1;
        e.board  = model_board;
        sbq.push_back(e);
        send_byte(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_glitch_busy", busy, 1'b0);
        chk("t5_board", board_out, model_board);

        // 6: async reset mid-payload
        send_byte(8'hA5, 1'b1);
        for (int k = 0; k < 10; k++) send_byte(8'hFF, 1'b1);
        chk("t6_busy_pre", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_board", board_out, '0);
        chk("t6_rst_busy", busy, 1'b0);
        model_board = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'(255 - k);
        send_frame(pay_xor(), 1'b1);
        chk("t6_board", board_out, pay_board());

        repeat (20) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        chk("valid_count", n_valid, 4);
        chk("err_count", n_err, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/board_uart_loader.md
Name: board_uart_loader

Overview:
- Serial board loader for the Game of Life design: receives a full board image over a UART 8N1 line and writes it as a flat cell vector.
- It is the writer into the same board format that the VGA display path reads: cell index = y*MAX_X + x, 1 = alive.
- The loaded image is committed only after a valid checksum. conway_fsm then takes board_out on the board_valid pulse.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
- MAX_X, 32, board width in cells.
- MAX_Y, 24, board height in cells; MAX_X*MAX_Y must be divisible by 8.
- TIMEOUT_CLKS, 50000, maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- rx_in  input  1  UART serial line, idles high, asynchronous to clk.
- board_out  output  MAX_X*MAX_Y  last committed board, bit i = cell i.
- board_valid  output  1  one-cycle pulse when board_out has just been updated.
- frame_err  output  1  one-cycle pulse on checksum, stop-bit or timeout failure.
- busy  output  1  high while a frame is in progress (past the sync byte).

Behaviour:
- Reset (rst=0, asynchronous): board_out=0, board_valid=0, frame_err=0, busy=0. Both FSMs go to their idle states and all counters and the staging register clear. A reset mid-frame discards the partial frame.
- Input conditioning: rx_in passes through a 2-FF synchronizer. All logic uses the synchronized value.
- Byte receiver FSM:
  - R_IDLE -> R_START on a synchronized high-to-low transition.
  - R_START: wait CLKS_PER_BIT/2 cycles, then resample. If low, go to R_DATA. If high, it was a false start: return to R_IDLE silently.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles. If high, pulse internal byte_done with the byte. If low, it is a framing error. Either way return to R_IDLE.
- Frame FSM:
  - F_SYNC: bytes other than 0xA5 are ignored silently. 0xA5 -> F_PAYLOAD, busy=1, byte counter=0, running XOR=0.
  - F_PAYLOAD: accepts NBYTES = MAX_X*MAX_Y/8 bytes (96 at defaults). Byte k fills staging bits [8k+7:8k] (bit 0 of the byte = cell 8k). Each byte is XORed into the running checksum. After byte NBYTES-1 -> F_CHECK.
  - F_CHECK: the next byte is the checksum.
    - If it equals the running XOR: board_out <= staging, and board_valid=1 in the same cycle board_out changes.
    - Otherwise: frame_err=1 and board_out is unchanged.
    - Both cases return to F_SYNC with busy=0.
- Latency: board_valid asserts 1 clk after the stop-bit sample of the checksum byte.
- Framing error:
  - In F_PAYLOAD or F_CHECK: frame_err pulse, return to F_SYNC, board_out unchanged.
  - In F_SYNC: no pulse.
- Timeout: while busy, a counter counts cycles since the last byte_done. When it reaches TIMEOUT_CLKS: frame_err pulse, return to F_SYNC. The counter resets on every byte_done.
- Sync byte inside payload: 0xA5 is treated as data. There is no in-band resync.
- board_valid and frame_err are never high in the same cycle.
- Line held low (break): one framing error, then the receiver waits for a high-to-low edge. It does not re-trigger while the line stays low.

Decomposition:
- Shared package/header (alongside the existing MAX_X/MAX_Y defines): SYNC_BYTE=8'hA5, CLKS_PER_BIT default, NBYTES derivation.
- One natural sub-module: uart_rx_byte (synchronizer plus byte receiver FSM; outputs byte_done, data[7:0], stop_err).
- board_uart_loader instantiates uart_rx_byte and holds the frame FSM, staging register, checksum and timeout logic.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CLKS=400 for simulation):
1. Reset, then send 0xA5, 96 bytes of 0x01, checksum 0x00 -> one board_valid pulse; board_out bit 8k = 1 for all k, all other bits 0; frame_err stays 0.
2. Same frame but checksum 0x01 -> frame_err pulse, no board_valid, board_out keeps its previous value.
3. Send 0x00, 0x3C, then a valid glider frame -> leading bytes ignored; board_valid pulses once; board_out matches the glider image.
4. 0xA5 plus 40 payload bytes, then idle for 500 cycles -> frame_err pulse about 400 cycles after the last byte; busy drops; a following valid frame loads normally.
5. Payload byte sent with stop bit = 0 -> frame_err pulse, return to F_SYNC. Separately, a 2-cycle low glitch on an idle line -> no byte, no error.
6. Assert rst=0 mid-payload after a prior successful load -> board_out=0, busy=0 immediately (asynchronous); the next full frame loads correctly.
